// File: rtl/snake_plot_sink.sv
// -----------------------------------------------------------------------------
// snake_plot_sink
//
// Pixel plot sink in front of a 160x120, 3-bit colour framebuffer.
// Plot requests are queued in an 8-entry FIFO and drained to the framebuffer
// write port under fb_ready handshaking. A clear request flushes the queue and
// fills every pixel with one colour. While a clear runs, plots are discarded.
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   rst           synchronous reset, active-high
//   plotEn        plot request strobe, sampled each cycle
//   x, y, colour  pixel column (0..159), row (0..119) and colour of the plot
//   clear_req     fill the whole screen with clear_colour
//   clear_colour  fill colour, sampled with clear_req
//   fb_ready      framebuffer accepts the presented write this cycle
//   fb_wren       framebuffer write valid
//   fb_addr       linear pixel address, y*160 + x
//   fb_data       pixel colour to write
//   busy          FIFO non-empty or clear in progress
//   full          FIFO holds 8 entries
//   dropped       one-cycle pulse after a plot request was discarded
//   clear_done    one-cycle pulse after the last clear write was accepted
//   count         FIFO occupancy, 0..8
// -----------------------------------------------------------------------------
module snake_plot_sink (
   input  logic        clk,
   input  logic        rst,
   input  logic        plotEn,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic [2:0]  colour,
   input  logic        clear_req,
   input  logic [2:0]  clear_colour,
   input  logic        fb_ready,
   output logic        fb_wren,
   output logic [14:0] fb_addr,
   output logic [2:0]  fb_data,
   output logic        busy,
   output logic        full,
   output logic        dropped,
   output logic        clear_done,
   output logic [3:0]  count
);

   localparam logic [14:0] LAST_ADDR = 15'd19199;
   localparam logic [3:0]  DEPTH     = 4'd8;

   typedef enum logic {
      DRAIN = 1'b0,
      CLEAR = 1'b1
   } state_e;

   typedef struct packed {
      logic [2:0] colour;
      logic [6:0] y;
      logic [7:0] x;
   } entry_t;

   state_e      state_q, state_d;
   entry_t      mem_q [8];
   entry_t      head;
   logic [2:0]  wr_ptr_q, wr_ptr_d;
   logic [2:0]  rd_ptr_q, rd_ptr_d;
   logic [3:0]  count_q, count_d;
   logic [14:0] clr_cnt_q, clr_cnt_d;
   logic [2:0]  clr_colour_q, clr_colour_d;
   logic        dropped_q, clear_done_q;
   logic        push, pop, clear_start, clear_last;
   logic [14:0] head_addr;

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   // Space is judged on the registered count only, so a pop in the same cycle
   // never makes room for a push.
   assign push = plotEn && (state_q == DRAIN) && (count_q < DEPTH)
              && (x <= 8'd159) && (y <= 7'd119) && !clear_req;
   assign pop  = (state_q == DRAIN) && (count_q != 4'd0) && fb_ready;

   assign clear_start = (state_q == DRAIN) && clear_req;
   assign clear_last  = (state_q == CLEAR) && (clr_cnt_q == LAST_ADDR) && fb_ready;

   assign head = mem_q[rd_ptr_q];
   // y*160 + x as two shifts and adds; the largest result (19199) fits in 15 bits.
   assign head_addr = {1'b0, head.y, 7'b0} + {3'b0, head.y, 5'b0} + {7'b0, head.x};

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential blocks use non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DRAIN;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DRAIN: if (clear_req)  state_d = CLEAR;
         CLEAR: if (clear_last) state_d = DRAIN;
         default: state_d = DRAIN;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      fb_wren = 1'b0;
      fb_addr = '0;
      fb_data = '0;
      unique case (state_q)
         DRAIN: begin
            fb_wren = (count_q != 4'd0);
            fb_addr = head_addr;
            fb_data = head.colour;
         end
         CLEAR: begin
            fb_wren = 1'b1;
            fb_addr = clr_cnt_q;
            fb_data = clr_colour_q;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      clr_cnt_d    = clr_cnt_q;
      clr_colour_d = clr_colour_q;

      if (clear_start) begin
         // Flush wins over any pop presented in the same cycle.
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         clr_cnt_d    = '0;
         clr_colour_d = clear_colour;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 3'd1;
         if (pop)  rd_ptr_d = rd_ptr_q + 3'd1;
         if (push && !pop)      count_d = count_q + 4'd1;
         else if (pop && !push) count_d = count_q - 4'd1;
         if ((state_q == CLEAR) && fb_ready) clr_cnt_d = clr_cnt_q + 15'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         clr_cnt_q    <= '0;
         clr_colour_q <= '0;
         dropped_q    <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         clr_cnt_q    <= clr_cnt_d;
         clr_colour_q <= clr_colour_d;
         dropped_q    <= plotEn && !push;
         clear_done_q <= clear_last;
      end
   end

   // NOTE: FIFO storage has no reset; an entry is only read after it was
   // written, so resetting it would add reset fan-out for no behaviour.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{colour: colour, y: y, x: x};
      end
   end

   // ---------------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------------
   assign busy       = (state_q == CLEAR) || (count_q != 4'd0);
   assign full       = (count_q == DEPTH);
   assign count      = count_q;
   assign dropped    = dropped_q;
   assign clear_done = clear_done_q;

endmodule

// File: tb/tb_snake_plot_sink.sv
// -----------------------------------------------------------------------------
// tb_snake_plot_sink
//
// Directed self-checking bench for snake_plot_sink. Inputs change 1 ns after
// a rising edge and outputs are compared at that same point, i.e. they show
// the registered state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_snake_plot_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic        plotEn;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        clear_req;
   logic [2:0]  clear_colour;
   logic        fb_ready;
   logic        fb_wren;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        busy;
   logic        full;
   logic        dropped;
   logic        clear_done;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   snake_plot_sink dut (
      .clk          (clk),
      .rst          (rst),
      .plotEn       (plotEn),
      .x            (x),
      .y            (y),
      .colour       (colour),
      .clear_req    (clear_req),
      .clear_colour (clear_colour),
      .fb_ready     (fb_ready),
      .fb_wren      (fb_wren),
      .fb_addr      (fb_addr),
      .fb_data      (fb_data),
      .busy         (busy),
      .full         (full),
      .dropped      (dropped),
      .clear_done   (clear_done),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int pix(input int px, input int py);
      return py * 160 + px;
   endfunction

   initial begin
      int exp_addr;
      int cyc;
      int bad;
      int cd_seen;

      rst = 1'b1; plotEn = 1'b0; x = '0; y = '0; colour = '0;
      clear_req = 1'b0; clear_colour = '0; fb_ready = 1'b0;

      // Reset state
      step(); step();
      rst = 1'b0;
      check("rst_wren",       fb_wren,    0);
      check("rst_busy",       busy,       0);
      check("rst_full",       full,       0);
      check("rst_count",      count,      0);
      check("rst_dropped",    dropped,    0);
      check("rst_clear_done", clear_done, 0);

      // Single plot, fb_ready high: visible the cycle after the push edge
      fb_ready = 1'b1;
      plotEn = 1'b1; x = 8'd10; y = 7'd2; colour = 3'd5;
      step();
      plotEn = 1'b0;
      check("single_wren",    fb_wren, 1);
      check("single_addr",    fb_addr, 330);
      check("single_data",    fb_data, 5);
      check("single_count",   count,   1);
      check("single_busy",    busy,    1);
      check("single_dropped", dropped, 0);
      step();
      check("single_count_after", count,   0);
      check("single_busy_after",  busy,    0);
      check("single_wren_after",  fb_wren, 0);

      // Back-pressure: 9 legal plots with fb_ready low, 9th is dropped
      fb_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
         plotEn = 1'b1;
         x = 8'(17 * k + 3); y = 7'(13 * k + 1); colour = 3'((k + 1) % 8);
         step();
         if (k == 7) begin
            check("bp_count_8",  count,   8);
            check("bp_full",     full,    1);
            check("bp_no_drop",  dropped, 0);
         end
      end
      plotEn = 1'b0;
      check("bp_drop_9th",   dropped, 1);
      check("bp_count_held", count,   8);
      step();
      check("bp_drop_once",  dropped, 0);
      check("bp_stall_addr", fb_addr, pix(3, 1));
      check("bp_stall_data", fb_data, 1);
      fb_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("drain%0d_wren", k), fb_wren, 1);
         check($sformatf("drain%0d_addr", k), fb_addr, pix(17 * k + 3, 13 * k + 1));
         check($sformatf("drain%0d_data", k), fb_data, (k + 1) % 8);
         step();
      end
      check("drain_empty_count", count,   0);
      check("drain_empty_wren",  fb_wren, 0);
      check("drain_not_full",    full,    0);

      // Simultaneous push and pop keeps count unchanged
      plotEn = 1'b1; x = 8'd159; y = 7'd119; colour = 3'd7;
      step();
      check("pp_count_a", count, 1);
      check("pp_addr_a",  fb_addr, 19199);
      x = 8'd0; y = 7'd1; colour = 3'd3;
      step();
      plotEn = 1'b0;
      check("pp_count_same", count,   1);
      check("pp_addr_b",     fb_addr, 160);
      check("pp_data_b",     fb_data, 3);
      step();
      check("pp_drained", count, 0);

      // Range check: out-of-range coordinates are dropped
      plotEn = 1'b1; x = 8'd160; y = 7'd0; colour = 3'd1;
      step();
      check("range_x_drop",  dropped, 1);
      check("range_x_count", count,   0);
      check("range_x_wren",  fb_wren, 0);
      x = 8'd0; y = 7'd120;
      step();
      plotEn = 1'b0;
      check("range_y_drop",  dropped, 1);
      check("range_y_count", count,   0);
      check("range_y_wren",  fb_wren, 0);
      step();
      check("range_drop_end", dropped, 0);

      // Clear with 3 entries queued
      fb_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         plotEn = 1'b1; x = 8'(k + 40); y = 7'(k + 5); colour = 3'd4;
         step();
      end
      plotEn = 1'b0;
      check("clr_pre_count", count, 3);
      fb_ready = 1'b1; clear_req = 1'b1; clear_colour = 3'd2;
      step();
      clear_req = 1'b0; clear_colour = 3'd0;
      check("clr_flush_count", count, 0);
      check("clr_busy",        busy,  1);
      exp_addr = 0; cyc = 0; bad = 0;
      while (exp_addr <= 19199 && cyc < 25000) begin
         fb_ready  = !(cyc == 300 || cyc == 301);
         plotEn    = (cyc == 100);
         x         = 8'd1; y = 7'd1; colour = 3'd6;
         clear_req = (cyc == 200);
         clear_colour = 3'd5;
         if (fb_wren !== 1'b1 || int'(fb_addr) != exp_addr || fb_data !== 3'd2
             || clear_done !== 1'b0 || count !== 4'd0)
            bad++;
         if (cyc == 101) check("clr_plot_dropped", dropped, 1);
         step();
         if (fb_ready) exp_addr++;
         cyc++;
      end
      plotEn = 1'b0; clear_req = 1'b0; fb_ready = 1'b1;
      check("clr_bad_cycles", bad,        0);
      check("clr_completed",  exp_addr,   19200);
      check("clr_done_pulse", clear_done, 1);
      check("clr_end_wren",   fb_wren,    0);
      check("clr_end_busy",   busy,       0);
      step();
      check("clr_done_once",  clear_done, 0);

      // Reset mid-clear at counter 500
      clear_req = 1'b1; clear_colour = 3'd6;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 500; i++) step();
      check("mid_addr_500", fb_addr, 500);
      check("mid_data",     fb_data, 6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_wren",  fb_wren,    0);
      check("mid_rst_busy",  busy,       0);
      check("mid_rst_count", count,      0);
      check("mid_rst_done",  clear_done, 0);
      cd_seen = 0;
      for (int i = 0; i < 19500; i++) begin
         if (clear_done !== 1'b0 || fb_wren !== 1'b0) cd_seen++;
         step();
      end
      check("mid_no_done_later", cd_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
